// File: rtl/bus_load_decoder.sv
// bus_load_decoder: queues 5-bit destination codes from the control unit in a
// small FIFO and drains one per cycle into a registered one-hot load enable
// for the bus-attached registers.
//
// Handshake: a code is accepted on a rising clk edge when req_valid && req_ready.
// req_ready depends only on the registered occupancy, never on req_valid, and
// stays low while full even if a pop happens at the same edge.
//
// Optional feature (macro LOAD_PROTECT_R0_EN): code 0 targets the hard-wired
// zero register. It is accepted and consumed but produces no load pulse, and it
// sets the sticky r0_write_err flag, which is cleared only by clr.
module bus_load_decoder #(
    parameter int NUM_DEST = 32,
    parameter int SEL_W    = 5,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     req_valid,
    input  logic [SEL_W-1:0]         req_sel,
    output logic                     req_ready,
    input  logic                     load_hold,
    output logic [NUM_DEST-1:0]      load_en,
    output logic [SEL_W-1:0]         load_sel,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending
`ifdef LOAD_PROTECT_R0_EN
    ,
    output logic                     r0_write_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
    localparam logic [NUM_DEST-1:0] ONE_HOT0 = NUM_DEST'(1);

    logic [SEL_W-1:0]    fifo_q [DEPTH];
    logic [SEL_W-1:0]    fifo_d [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_DEST-1:0] load_en_q, load_en_d;
    logic [SEL_W-1:0]    load_sel_q, load_sel_d;
`ifdef LOAD_PROTECT_R0_EN
    logic                r0_err_q, r0_err_d;
`endif

    logic                push;
    logic                pop;
    logic [SEL_W-1:0]    head;

    // Ready comes from registered occupancy only, so no bypass when full.
    assign req_ready = (count_q < FULL_CNT);

    // Next-state logic for FIFO storage, pointers, occupancy and load outputs.
    always_comb begin
        push       = req_valid && req_ready;
        pop        = (count_q != '0) && !load_hold;
        head       = fifo_q[rd_ptr_q];
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        load_en_d  = '0;
        load_sel_d = load_sel_q;
`ifdef LOAD_PROTECT_R0_EN
        r0_err_d   = r0_err_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = req_sel;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        // The pop looks only at registered state: a code pushed at this edge
        // cannot be popped until the next one.
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            load_en_d  = ONE_HOT0 << head;
            load_sel_d = head;
`ifdef LOAD_PROTECT_R0_EN
            if (head == '0) begin
                load_en_d  = '0;
                load_sel_d = load_sel_q;
                r0_err_d   = 1'b1;
            end
`endif
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; clr discards everything at once, including queued codes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            load_en_q  <= '0;
            load_sel_q <= '0;
`ifdef LOAD_PROTECT_R0_EN
            r0_err_q   <= 1'b0;
`endif
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            load_en_q  <= load_en_d;
            load_sel_q <= load_sel_d;
`ifdef LOAD_PROTECT_R0_EN
            r0_err_q   <= r0_err_d;
`endif
        end
    end

    assign load_en  = load_en_q;
    assign load_sel = load_sel_q;
    assign pending  = count_q;
    assign busy     = (count_q != '0) || (load_en_q != '0);
`ifdef LOAD_PROTECT_R0_EN
    assign r0_write_err = r0_err_q;
`endif

endmodule

// File: tb/tb_bus_load_decoder.sv
// Bench for bus_load_decoder: a queue-based model of the pending codes plus
// directed scenarios with hand-computed load enables.
module tb_bus_load_decoder;

    localparam int NUM_DEST = 32;
    localparam int SEL_W    = 5;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                clr = 1'b1;
    logic                req_valid = 1'b0;
    logic [SEL_W-1:0]    req_sel = '0;
    logic                req_ready;
    logic                load_hold = 1'b0;
    logic [NUM_DEST-1:0] load_en;
    logic [SEL_W-1:0]    load_sel;
    logic                busy;
    logic [2:0]          pending;
`ifdef LOAD_PROTECT_R0_EN
    logic                r0_write_err;
`endif

    int checks = 0;
    int errors = 0;

    bus_load_decoder #(.NUM_DEST(NUM_DEST), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .load_hold (load_hold),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .busy      (busy),
        .pending   (pending)
`ifdef LOAD_PROTECT_R0_EN
        ,
        .r0_write_err (r0_write_err)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pending codes as a plain queue; at an edge the pop sees the queue as it
    // was before the edge, then an accepted push is appended.
    logic [SEL_W-1:0]    mq[$];
    logic [NUM_DEST-1:0] m_en  = '0;
    logic [SEL_W-1:0]    m_sel = '0;
    logic                m_err = 1'b0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mq.delete();
            m_en  = '0;
            m_sel = '0;
            m_err = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            logic [SEL_W-1:0] code;
            do_push = req_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() > 0) && !load_hold;
            m_en = '0;
            if (do_pop) begin
                code = mq.pop_front();
`ifdef LOAD_PROTECT_R0_EN
                if (code == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_en  = NUM_DEST'(1) << code;
                    m_sel = code;
                end
`else
                m_en  = NUM_DEST'(1) << code;
                m_sel = code;
`endif
            end
            if (do_push) mq.push_back(req_sel);
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [SEL_W-1:0] seen_q[$];
    bit               rec_en = 1'b0;

    always @(negedge clk) begin
        check("cmp_load_en",   load_en, m_en);
        check("cmp_load_sel",  load_sel, m_sel);
        check("cmp_pending",   pending, mq.size());
        check("cmp_req_ready", req_ready, mq.size() < DEPTH);
        check("cmp_busy",      busy, (mq.size() != 0) || (m_en != 0));
        check("cmp_onehot0",   $onehot0(load_en), 1'b1);
`ifdef LOAD_PROTECT_R0_EN
        check("cmp_r0_err",    r0_write_err, m_err);
`endif
        if (rec_en && load_en != 0) seen_q.push_back(load_sel);
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [SEL_W-1:0] c);
        req_valid = 1'b1;
        req_sel   = c;
        step();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2 clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [SEL_W-1:0] wcodes[12];
        int idx;
        int cyc;
        bit rdy;

        // Reset state while clr is high.
        #1;
        check("rst_load_en",   load_en, 0);
        check("rst_load_sel",  load_sel, 0);
        check("rst_pending",   pending, 0);
        check("rst_busy",      busy, 0);
        check("rst_req_ready", req_ready, 1);
        step();
        clr = 1'b0;
        step();

        // Single load of code 5.
        push_code(5);
        req_valid = 1'b0;
        check("single_pre_en",   load_en, 0);
        check("single_pending1", pending, 1);
        check("single_busy1",    busy, 1);
        step();
        check("single_en",     load_en, 32'h0000_0020);
        check("single_sel",    load_sel, 5);
        check("single_busy2",  busy, 1);
        step();
        check("single_en_off", load_en, 0);
        check("single_sel_hold", load_sel, 5);
        check("single_busy_off", busy, 0);

        // Back-to-back pushes 0,1,2,31.
        push_code(0);
        push_code(1);
`ifdef LOAD_PROTECT_R0_EN
        check("b2b_en0", load_en, 32'h0000_0000);
`else
        check("b2b_en0", load_en, 32'h0000_0001);
`endif
        push_code(2);
        check("b2b_en1", load_en, 32'h0000_0002);
        push_code(31);
        check("b2b_en2", load_en, 32'h0000_0004);
        idle(1);
        check("b2b_en31", load_en, 32'h8000_0000);
        check("b2b_sel31", load_sel, 31);
        idle(1);
        check("b2b_done", load_en, 0);

        // Full / backpressure with load_hold.
        load_hold = 1'b1;
        push_code(4);
        push_code(8);
        push_code(12);
        push_code(16);
        check("full_pending", pending, 4);
        check("full_ready",   req_ready, 0);
        push_code(20);
        req_valid = 1'b0;
        check("full_pending2", pending, 4);
        check("full_hold_en",  load_en, 0);
        load_hold = 1'b0;
        step();
        check("full_pop4",  load_en, 32'h0000_0010);
        check("full_ready_up", req_ready, 1);
        check("full_pend3", pending, 3);
        step();
        check("full_pop8",  load_en, 32'h0000_0100);
        step();
        check("full_pop12", load_en, 32'h0000_1000);
        step();
        check("full_pop16", load_en, 32'h0001_0000);
        step();
        check("full_no20",  load_en, 0);
        check("full_empty", pending, 0);

        // Reset mid-drain: 3,7,9 queued under hold, clr after the first pop.
        load_hold = 1'b1;
        push_code(3);
        push_code(7);
        push_code(9);
        req_valid = 1'b0;
        load_hold = 1'b0;
        step();
        check("mid_pop3", load_en, 32'h0000_0008);
        #2 clr = 1'b1;
        #1;
        check("mid_clr_en",    load_en, 0);
        check("mid_clr_pend",  pending, 0);
        check("mid_clr_ready", req_ready, 1);
        check("mid_clr_busy",  busy, 0);
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_pulse", load_en, 0);
        end

        // Wrap-around stream 10..21, valid held, hold toggled every 3 cycles.
        for (int i = 0; i < 12; i++) wcodes[i] = SEL_W'(10 + i);
        seen_q.delete();
        rec_en = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 12 && cyc < 200) begin
            load_hold = ((cyc / 3) % 2) == 1;
            req_valid = 1'b1;
            req_sel   = wcodes[idx];
            rdy       = req_ready;
            step();
            check("wrap_pending_max", pending <= 4, 1);
            if (rdy) idx++;
            cyc++;
        end
        check("wrap_all_pushed", idx, 12);
        req_valid = 1'b0;
        load_hold = 1'b0;
        idle(8);
        rec_en = 1'b0;
        check("wrap_count", seen_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < seen_q.size()) check("wrap_order", seen_q[i], 10 + i);
        end

`ifdef LOAD_PROTECT_R0_EN
        // R0 protection: 0 is dropped, 6 loads, error flag sticks until clr.
        do_reset();
        check("r0_err_reset", r0_write_err, 0);
        push_code(0);
        push_code(6);
        req_valid = 1'b0;
        check("r0_drop_en",  load_en, 0);
        check("r0_err_set",  r0_write_err, 1);
        step();
        check("r0_load6",    load_en, 32'h0000_0040);
        step();
        idle(3);
        check("r0_err_sticky", r0_write_err, 1);
        do_reset();
        check("r0_err_cleared", r0_write_err, 0);
`else
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
